// File: rtl/and_tx_pkg.sv
// Shared types and constants for the AND-result UART transmitter.
package and_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/and_result_uart_tx_fifo.sv
// Synchronous circular FIFO with first-word fall-through read data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/and_result_uart_tx.sv
// Buffers AND-stage result bytes and serialises them as UART frames on tx.
// Define AND_RESULT_UART_TX_PARITY_EN to insert an even-parity bit before stop.
module and_result_uart_tx
  import and_tx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ena,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t      state, state_n;
  logic [BW-1:0]  baud, baud_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift, shift_n;
  logic           tx_q, tx_n;
  logic           push, pop, full, empty, bit_end;
  logic [7:0]     head;
`ifdef AND_RESULT_UART_TX_PARITY_EN
  logic           par, par_n;
`endif

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = ena && !full;
  assign push     = in_valid && in_ready;
  assign tx       = tx_q;
  assign tx_busy  = (state != IDLE);
  assign bit_end  = (baud == LAST_TICK);

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    pop       = 1'b0;
`ifdef AND_RESULT_UART_TX_PARITY_EN
    par_n     = par;
`endif
    if (ena) begin
      case (state)
        IDLE: begin
          baud_n = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_n   = head;
            bit_idx_n = '0;
            state_n   = START;
`ifdef AND_RESULT_UART_TX_PARITY_EN
            par_n     = even_parity(head);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_n    = '0;
            bit_idx_n = '0;
            state_n   = DATA;
          end else begin
            baud_n = baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_n    = '0;
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef AND_RESULT_UART_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            baud_n = baud + BW'(1);
          end
        end
`ifdef AND_RESULT_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_n  = '0;
            state_n = STOP;
          end else begin
            baud_n = baud + BW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_n  = '0;
            state_n = IDLE;
          end else begin
            baud_n = baud + BW'(1);
          end
        end
        default: begin
          baud_n  = '0;
          state_n = IDLE;
        end
      endcase

      // tx is registered, so it is derived from the state being entered
      case (state_n)
        START:   tx_n = START_LEVEL;
        DATA:    tx_n = shift_n[0];
`ifdef AND_RESULT_UART_TX_PARITY_EN
        PARITY:  tx_n = par_n;
`endif
        default: tx_n = IDLE_LEVEL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= IDLE_LEVEL;
`ifdef AND_RESULT_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
`ifdef AND_RESULT_UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_and_result_uart_tx.sv
// Directed self-checking bench for and_result_uart_tx (DEPTH=4, CLKS_PER_BIT=4).
module tb_and_result_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef AND_RESULT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic                       clk = 1'b0;
  logic                       reset, ena, in_valid, in_ready, tx, tx_busy;
  logic [7:0]                 in_data;
  logic [$clog2(D+1)-1:0]     fifo_count;
  int                         n_cmp = 0;
  int                         n_bad = 0;
  int                         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  and_result_uart_tx #(
    .DEPTH(D),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef AND_RESULT_UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Receives one frame: waits for the start bit, then samples every cycle of every bit.
  task automatic rx_frame(input int budget, output logic [7:0] data, output logic par,
                          output logic stop, output logic stable, output logic tmo,
                          output int t0);
    logic [10:0] b;
    int n;
    b = '0; n = 0; stable = 1'b1; tmo = 1'b0;
    data = '0; par = 1'b0; stop = 1'b0; t0 = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    t0 = cyc;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < C; j++) begin
        if (j == 0) b[i] = tx;
        else if (tx !== b[i]) stable = 1'b0;
        tick();
      end
    end
    data = b[8:1];
    par  = (NB == 11) ? b[9] : 1'b0;
    stop = b[NB-1];
    if (b[0] !== 1'b0) stable = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    reset = 1'b0;
    highs = 0;
    repeat (20) begin
      tick();
      if (tx === 1'b1 && tx_busy === 1'b0) highs++;
    end
    n_cmp++; if (highs != 20) begin n_bad++; $display("FAIL idle_high: got %0d expected 20", highs); end
  endtask

  task automatic test_single();
    logic [63:0] got, exp;
    logic [10:0] fb;
    int busy;
`ifdef AND_RESULT_UART_TX_PARITY_EN
    fb = 11'b1_0_10100101_0;
`else
    fb = 11'b0_1_10100101_0;
`endif
    got = '0; exp = '0; busy = 0;
    for (int i = 0; i < FL; i++) exp[i] = fb[i / C];
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count_acc: got %0d expected 1", fifo_count); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_acc: got %b expected 1", tx); end
    tick();
    for (int i = 0; i < FL + 5; i++) begin
      if (i < FL) got[i] = tx;
      if (tx_busy === 1'b1) busy++;
      tick();
    end
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL single_seq: got %h expected %h", got, exp); end
    n_cmp++; if (busy != FL) begin n_bad++; $display("FAIL single_busy: got %0d expected %0d", busy, FL); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_count_end: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [6];
    int         t [6];
    int         acc_cyc [6];
    int         rel_exp [6];
    logic [2:0] cnts [5];
    logic [2:0] cnt_exp [5];
    logic       rdy4, bad_frame, tmo_any, p, s, st, tm, acc;
    int         k, n;
    rel_exp = '{0, 1, 2, 3, 4, FL + 3};
    cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    acc_cyc = '{default: 0};
    t       = '{default: 0};
    cnts    = '{default: 3'd0};
    rdy4 = 1'b1; bad_frame = 1'b0; tmo_any = 1'b0;
    fork
      begin
        k = 0; n = 0; in_valid = 1'b1;
        while (k < 6 && n < 300) begin
          in_data = 8'(k + 1);
          acc = in_ready;
          tick();
          n++;
          if (acc) begin
            acc_cyc[k] = cyc;
            if (k < 5) cnts[k] = fifo_count;
            if (k == 4) rdy4 = in_ready;
            k++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) begin
          rx_frame(300, got[f], p, s, st, tm, t[f]);
          if (tm) tmo_any = 1'b1;
          if (!st || s !== 1'b1) bad_frame = 1'b1;
        end
      end
    join
    n_cmp++; if (tmo_any) begin n_bad++; $display("FAIL bp_timeout: got timeout expected 6 frames"); end
    n_cmp++; if (bad_frame) begin n_bad++; $display("FAIL bp_framing: got bad start/stop/width expected clean frames"); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[0] != rel_exp[i]) begin
        n_bad++; $display("FAIL bp_accept_%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[0], rel_exp[i]);
      end
      n_cmp++;
      if (got[i] !== 8'(i + 1)) begin
        n_bad++; $display("FAIL bp_order_%0d: got %h expected %h", i, got[i], 8'(i + 1));
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cnts[i] !== cnt_exp[i]) begin
        n_bad++; $display("FAIL bp_count_%0d: got %0d expected %0d", i, cnts[i], cnt_exp[i]);
      end
    end
    n_cmp++; if (rdy4 !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b expected 0", rdy4); end
    n_cmp++; if (t[0] - acc_cyc[0] != 1) begin n_bad++; $display("FAIL bp_first_pop: got %0d expected 1", t[0] - acc_cyc[0]); end
    for (int i = 1; i < 6; i++) begin
      n_cmp++;
      if (t[i] - t[i-1] != FL + 1) begin
        n_bad++; $display("FAIL bp_spacing_%0d: got %0d expected %0d", i, t[i] - t[i-1], FL + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] got, exp;
    logic [10:0] fb;
    logic        rdy_stall;
    int          bi;
    fb = frame_bits(8'h3C);
    got = '0; exp = '0; rdy_stall = 1'b1;
    // bit 3 of the frame is stretched by the 7 stalled cycles
    for (int i = 0; i < FL + 7; i++) begin
      if (i < 3 * C) bi = i / C;
      else if (i < 3 * C + C + 7) bi = 3;
      else bi = (i - 7) / C;
      exp[i] = fb[bi];
    end
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < FL + 7; i++) begin
      ena = (i >= 3 * C + 2 && i < 3 * C + 9) ? 1'b0 : 1'b1;
      got[i] = tx;
      if (i == 3 * C + 5) begin
        #1;
        rdy_stall = in_ready;
      end
      tick();
    end
    ena = 1'b1;
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL stall_seq: got %h expected %h", got, exp); end
    n_cmp++; if (rdy_stall !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b expected 0", rdy_stall); end
    n_cmp++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++; $display("FAIL stall_end: got busy=%b tx=%b expected busy=0 tx=1", tx_busy, tx);
    end
  endtask

  task automatic test_reset_mid();
    int active;
    in_valid = 1'b1;
    in_data = 8'hFF; tick();
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    repeat (16) tick();
    n_cmp++; if (tx_busy !== 1'b1 || fifo_count !== 3'd2) begin
      n_bad++; $display("FAIL rmid_pre: got busy=%b count=%0d expected busy=1 count=2", tx_busy, fifo_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rmid_tx: got %b expected 1", tx); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (tx_busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rmid_state: got busy=%b ready=%b expected busy=0 ready=1", tx_busy, in_ready);
    end
    active = 0;
    repeat (120) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) active++;
    end
    n_cmp++; if (active != 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", active); end
  endtask

`ifdef AND_RESULT_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d1, d2;
    logic       p1, p2, s1, s2, st1, st2, tm1, tm2;
    int         t1, t2;
    in_valid = 1'b1;
    in_data = 8'h07; tick();
    in_data = 8'h03; tick();
    in_valid = 1'b0;
    rx_frame(100, d1, p1, s1, st1, tm1, t1);
    rx_frame(100, d2, p2, s2, st2, tm2, t2);
    n_cmp++; if (tm1 || tm2 || !st1 || !st2) begin n_bad++; $display("FAIL par_frames: got tmo=%b%b stable=%b%b expected clean", tm1, tm2, st1, st2); end
    n_cmp++; if (d1 !== 8'h07 || d2 !== 8'h03) begin n_bad++; $display("FAIL par_data: got %h %h expected 07 03", d1, d2); end
    n_cmp++; if (p1 !== 1'b1) begin n_bad++; $display("FAIL par_bit_07: got %b expected 1", p1); end
    n_cmp++; if (p2 !== 1'b0) begin n_bad++; $display("FAIL par_bit_03: got %b expected 0", p2); end
    n_cmp++; if (s1 !== 1'b1 || s2 !== 1'b1) begin n_bad++; $display("FAIL par_stop: got %b %b expected 1 1", s1, s2); end
    n_cmp++; if (t2 - t1 != 45) begin n_bad++; $display("FAIL par_period: got %0d expected 45", t2 - t1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stall();
    test_reset_mid();
`ifdef AND_RESULT_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
